// File: rtl/leaf_pkt_pkg.sv
// Shared field layout, credit limits and packet assembly for the leaf TX packetizer.
package leaf_pkt_pkg;

    localparam int PKT_W     = 49;
    localparam int PAYLOAD_W = 32;
    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;

    localparam int VALID_BIT = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;

    localparam int CREDIT_MAX = 1 << ADDR_W;
    localparam int CREDIT_W   = ADDR_W + 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic logic [PKT_W-1:0] build_packet(
        input logic [LEAF_W-1:0]    leaf,
        input logic [PORT_W-1:0]    port,
        input logic [ADDR_W-1:0]    addr,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {1'b1, leaf, port, addr, payload};
    endfunction

endpackage

// File: rtl/leaf_tx_packetizer_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above the pointer wins, else lowest overall.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] hi_idx, lo_idx;
    logic             hi_any, lo_any;

    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = IDX_W'(i);
                if (i >= int'(ptr_q)) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
        gnt_idx = hi_any ? hi_idx : lo_idx;
        gnt_any = en && lo_any;
        gnt     = gnt_any ? (N'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/leaf_tx_packetizer.sv
// Leaf TX packetizer: round-robin over user streams, stamps dst/addr, enforces credits, one-entry output register.
module leaf_tx_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                                  clk_user,
    input  logic                                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]                 din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                              ack_interface2user,
    input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dst_cfg,
    input  logic                                                  credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                              credit_upd_port,
    output logic [PACKET_BITS-1:0]                                dout_leaf_interface2bft,
    input  logic                                                  bft_ready
);

    localparam int CFG_W = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

    out_state_t state_q, state_d;

    logic [CREDIT_W-1:0]      credit_q [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
    logic [CFG_W-1:0]         cfg_arr  [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]  din_arr  [NUM_OUT_PORTS];

    logic [NUM_OUT_PORTS-1:0] req, gnt, upd_hit;
    logic [IDX_W-1:0]         gnt_idx;
    logic                     gnt_any, grant_en;
    logic [PACKET_BITS-1:0]   pkt_p1;

    function automatic logic [CREDIT_W-1:0] next_credit(
        input logic [CREDIT_W-1:0] cur,
        input logic                dec,
        input logic                inc
    );
        int sum;
        sum = int'(cur) - int'(dec) + (inc ? FREESPACE_UPDATE_SIZE : 0);
        if (sum > CREDIT_MAX) sum = CREDIT_MAX;
        return CREDIT_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            cfg_arr[i] = dst_cfg[i*CFG_W +: CFG_W];
            din_arr[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            req[i]     = vld_user2interface[i] && (credit_q[i] != '0);
            upd_hit[i] = credit_upd_vld && (int'(credit_upd_port) == i);
        end
    end

    // Reset suppresses grants so no ack escapes during the reset cycle.
    assign grant_en = !reset && ((state_q == OUT_EMPTY) || bft_ready);

    rr_arbiter #(
        .N     (NUM_OUT_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk_user),
        .reset   (reset),
        .en      (grant_en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign ack_interface2user = gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (gnt_any) state_d = OUT_FULL;
            OUT_FULL:  if (bft_ready) state_d = gnt_any ? OUT_FULL : OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_user) begin
        if (reset) state_q <= OUT_EMPTY;
        else       state_q <= state_d;
    end

    // Stage p1: output register, reloaded on grant, cleared when drained.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            pkt_p1 <= '0;
        end else if (gnt_any) begin
            pkt_p1 <= build_packet(cfg_arr[gnt_idx][CFG_W-1 -: NUM_LEAF_BITS],
                                   cfg_arr[gnt_idx][NUM_PORT_BITS-1:0],
                                   addr_q[gnt_idx], din_arr[gnt_idx]);
        end else if (state_q == OUT_FULL && bft_ready) begin
            pkt_p1 <= '0;
        end
    end

    assign dout_leaf_interface2bft = pkt_p1;

    always_ff @(posedge clk_user) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= CREDIT_W'(CREDIT_MAX);
                addr_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= next_credit(credit_q[i], gnt[i], upd_hit[i]);
                if (gnt[i]) addr_q[i] <= addr_q[i] + 1'b1;
            end
        end
    end

endmodule
